// File: rtl/commit_checker_pkg.sv
// Shared types for the in-order commit checker: FSM states, error codes and
// the commit record carried through the expected-record FIFO.
// Optional build macro: COMMIT_CHECKER_MEM_CHECK_EN adds the memory-write
// fields to the record so memory writes are stored and compared.
package commit_checker_pkg;

  // Widest field sizes a record can carry. Instances may use narrower
  // ports; values are zero-extended into the record, which keeps the
  // field-by-field comparison exact.
  localparam int unsigned REC_ADDR_W = 32;
  localparam int unsigned REC_DATA_W = 32;
  localparam int unsigned REC_REG_W  = 5;

  // Architectural zero register: writes to it are treated as no write.
  localparam logic [REC_REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_PC        = 3'd1,
    ERR_REG       = 3'd2,
    ERR_MEM       = 3'd3,
    ERR_UNDERFLOW = 3'd4,
    ERR_LEFTOVER  = 3'd5,
    ERR_HANG      = 3'd6
  } err_kind_e;

  typedef struct packed {
    logic [REC_ADDR_W-1:0] pc;
    logic                  rd_we;
    logic [REC_REG_W-1:0]  rd;
    logic [REC_DATA_W-1:0] rd_data;
`ifdef COMMIT_CHECKER_MEM_CHECK_EN
    logic                  mem_we;
    logic [REC_ADDR_W-1:0] mem_addr;
    logic [REC_DATA_W-1:0] mem_data;
`endif
  } commit_rec_t;

  // A register write only counts when it targets a non-zero register.
  function automatic logic rd_write_eff(input logic we, input logic [REC_REG_W-1:0] rd);
    return we && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Single-clock FIFO of expected commit records. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate flag.
// A clear in the same cycle as a push restarts the queue holding just the
// pushed record.
module commit_fifo
  import commit_checker_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  commit_rec_t data_i,
  input  logic        pop_i,
  output commit_rec_t data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam int unsigned PTR_W = AW + 1;

  commit_rec_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             rd_en;

  assign wr_en  = push_i && (clear_i || !full_o);
  assign rd_en  = pop_i && !empty_o && !clear_i;
  assign wr_idx = clear_i ? '0 : wr_ptr_q[AW-1:0];

  // Storage write port.
  // NOTE: the array is deliberately not reset; only the pointers are, so the
  // storage maps onto plain RAM and stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  // Pointer update: reset and clear empty the queue, otherwise advance.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // block sees the pre-edge value of every register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= wr_en ? PTR_W'(1) : '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/commit_checker.sv
// In-order retirement checker. A reference model queues expected commit
// records; each retired CPU instruction is compared against the oldest one.
// Mismatches are counted, the first failure is captured, and hangs and
// leftover expectations at program end are reported.
// Optional build macro: COMMIT_CHECKER_MEM_CHECK_EN enables storing and
// comparing the memory-write fields (error kind MEM). Without it the
// exp_mem_* and dut_mem_* inputs are ignored.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HANG_CYCLES = 600,
  parameter int unsigned MAX_ERR     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              done_i,
  // expected-record handshake
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [ADDR_W-1:0] exp_pc_i,
  input  logic              exp_rd_we_i,
  input  logic [REG_W-1:0]  exp_rd_i,
  input  logic [DATA_W-1:0] exp_rd_data_i,
  input  logic              exp_mem_we_i,
  input  logic [ADDR_W-1:0] exp_mem_addr_i,
  input  logic [DATA_W-1:0] exp_mem_data_i,
  // actual commit from the CPU, no backpressure
  input  logic              dut_valid_i,
  input  logic [ADDR_W-1:0] dut_pc_i,
  input  logic              dut_rd_we_i,
  input  logic [REG_W-1:0]  dut_rd_i,
  input  logic [DATA_W-1:0] dut_rd_data_i,
  input  logic              dut_mem_we_i,
  input  logic [ADDR_W-1:0] dut_mem_addr_i,
  input  logic [DATA_W-1:0] dut_mem_data_i,
  // status
  output logic              busy_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [7:0]        err_cnt_o,
  output logic [15:0]       commit_cnt_o,
  output logic [2:0]        err_kind_o,
  output logic [15:0]       err_index_o
);

  localparam int unsigned     HANG_W     = $clog2(HANG_CYCLES + 1);
  localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_CYCLES - 1);
  localparam logic [7:0]      MAX_ERR_L  = 8'(MAX_ERR);

  state_e             state_q;
  logic               busy_q;
  logic               pass_q;
  logic               fail_q;
  logic [7:0]         err_cnt_q;
  logic [7:0]         err_cnt_d;
  logic [15:0]        commit_cnt_q;
  logic [15:0]        commit_cnt_d;
  err_kind_e          err_kind_q;
  logic [15:0]        err_index_q;
  logic [HANG_W-1:0]  hang_q;

  commit_rec_t        exp_rec;
  commit_rec_t        dut_rec;
  commit_rec_t        head_rec;
  logic               fifo_full;
  logic               fifo_empty;
  logic [$clog2(DEPTH):0] unused_fifo_count;
  logic               push;
  logic               pop;

  err_kind_e          cmp_kind;
  err_kind_e          ev_kind;
  logic               ev_err;
  logic               ev_fatal;
  logic               exp_we_eff;
  logic               dut_we_eff;
  logic               reg_mis;

  // Pack the expected and actual ports into records of the shared type.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    exp_rec         = '0;
    exp_rec.pc      = REC_ADDR_W'(exp_pc_i);
    exp_rec.rd_we   = exp_rd_we_i;
    exp_rec.rd      = REC_REG_W'(exp_rd_i);
    exp_rec.rd_data = REC_DATA_W'(exp_rd_data_i);
    dut_rec         = '0;
    dut_rec.pc      = REC_ADDR_W'(dut_pc_i);
    dut_rec.rd_we   = dut_rd_we_i;
    dut_rec.rd      = REC_REG_W'(dut_rd_i);
    dut_rec.rd_data = REC_DATA_W'(dut_rd_data_i);
`ifdef COMMIT_CHECKER_MEM_CHECK_EN
    exp_rec.mem_we   = exp_mem_we_i;
    exp_rec.mem_addr = REC_ADDR_W'(exp_mem_addr_i);
    exp_rec.mem_data = REC_DATA_W'(exp_mem_data_i);
    dut_rec.mem_we   = dut_mem_we_i;
    dut_rec.mem_addr = REC_ADDR_W'(dut_mem_addr_i);
    dut_rec.mem_data = REC_DATA_W'(dut_mem_data_i);
`endif
  end

`ifndef COMMIT_CHECKER_MEM_CHECK_EN
  logic unused_mem;
  assign unused_mem = ^{exp_mem_we_i, exp_mem_addr_i, exp_mem_data_i,
                        dut_mem_we_i, dut_mem_addr_i, dut_mem_data_i};
`endif

  // Ready comes from registered state and count only; a same-cycle pop
  // never opens a slot, and a commit never sees a same-cycle push.
  assign exp_ready_o = (state_q == ST_RUN) && !fifo_full;
  assign push        = exp_valid_i && exp_ready_o;
  assign pop         = (state_q == ST_RUN) && !start_i && dut_valid_i && !fifo_empty;

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (start_i),
    .push_i  (push),
    .data_i  (exp_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  assign exp_we_eff = rd_write_eff(head_rec.rd_we, head_rec.rd);
  assign dut_we_eff = rd_write_eff(dut_rec.rd_we, dut_rec.rd);
  assign reg_mis    = (exp_we_eff != dut_we_eff) ||
                      (exp_we_eff && dut_we_eff &&
                       ((head_rec.rd != dut_rec.rd) || (head_rec.rd_data != dut_rec.rd_data)));

  // Field comparison of the FIFO head against the commit, PC first.
  always_comb begin
    cmp_kind = ERR_NONE;
    if (head_rec.pc != dut_rec.pc) begin
      cmp_kind = ERR_PC;
    end else if (reg_mis) begin
      cmp_kind = ERR_REG;
    end
`ifdef COMMIT_CHECKER_MEM_CHECK_EN
    else if ((head_rec.mem_we != dut_rec.mem_we) ||
             (head_rec.mem_we && dut_rec.mem_we &&
              ((head_rec.mem_addr != dut_rec.mem_addr) ||
               (head_rec.mem_data != dut_rec.mem_data)))) begin
      cmp_kind = ERR_MEM;
    end
`endif
  end

  // Error event for the current RUN cycle: commit mismatch, underflow or hang.
  always_comb begin
    ev_kind = ERR_NONE;
    if (dut_valid_i) begin
      ev_kind = fifo_empty ? ERR_UNDERFLOW : cmp_kind;
    end else if (hang_q == HANG_LAST) begin
      ev_kind = ERR_HANG;
    end
  end

  assign ev_err       = (ev_kind != ERR_NONE);
  assign err_cnt_d    = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign commit_cnt_d = (commit_cnt_q == 16'hFFFF) ? commit_cnt_q : commit_cnt_q + 16'd1;
  assign ev_fatal     = (ev_kind == ERR_HANG) || (ev_err && (err_cnt_d >= MAX_ERR_L));

  // Checker FSM with its counters, first-error capture and registered verdicts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      commit_cnt_q <= '0;
      err_kind_q   <= ERR_NONE;
      err_index_q  <= '0;
      hang_q       <= '0;
    end else if (start_i) begin
      // Start wins from any state, including a same-cycle done_i.
      state_q      <= ST_RUN;
      busy_q       <= 1'b1;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      commit_cnt_q <= '0;
      err_kind_q   <= ERR_NONE;
      err_index_q  <= '0;
      hang_q       <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          hang_q <= dut_valid_i ? '0 : hang_q + HANG_W'(1);
          if (pop) begin
            commit_cnt_q <= commit_cnt_d;
          end
          if (ev_err) begin
            err_cnt_q <= err_cnt_d;
            if (err_kind_q == ERR_NONE) begin
              err_kind_q  <= ev_kind;
              err_index_q <= commit_cnt_q;
            end
          end
          if (ev_fatal) begin
            state_q <= ST_FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else if (done_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          busy_q <= 1'b0;
          if (!fifo_empty) begin
            err_cnt_q <= err_cnt_d;
            if (err_kind_q == ERR_NONE) begin
              err_kind_q  <= ERR_LEFTOVER;
              err_index_q <= commit_cnt_q;
            end
            state_q <= ST_FAIL;
            fail_q  <= 1'b1;
          end else if (err_cnt_q == '0) begin
            state_q <= ST_PASS;
            pass_q  <= 1'b1;
          end else begin
            state_q <= ST_FAIL;
            fail_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE, PASS and FAIL hold until start_i.
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign err_cnt_o    = err_cnt_q;
  assign commit_cnt_o = commit_cnt_q;
  assign err_kind_o   = err_kind_q;
  assign err_index_o  = err_index_q;

endmodule
